// File: rtl/data_path_pkg.sv
// Shared constants for the data path: widths, IR field positions and ALU opcodes.
package data_path_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_GPR    = 16;
    localparam int unsigned REG_IDX_W  = 4;
    localparam int unsigned RAM_DEPTH  = 512;
    localparam int unsigned RAM_ADDR_W = 9;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned OP_W       = 5;

    // IR field positions
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_LSB = 15;
    localparam int unsigned C2_LSB = 19;
    localparam int unsigned C2_W   = 2;
    localparam int unsigned IMM_W  = 19;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } alu_result_t;

    function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit {hi,lo} result.
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              inc_pc,
    output alu_result_t       result_c
);

    logic [SHAMT_W-1:0]  shamt;
    logic [2*DATA_W-1:0] prod;
    logic [5:0]          rot_back;

    assign shamt    = b[SHAMT_W-1:0];
    assign rot_back = 6'(DATA_W) - 6'(shamt);
    // Sign-extended operands make the low 64 bits of the product the signed result
    assign prod     = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};

    always_comb begin
        result_c = '0;
        if (inc_pc) begin
            result_c.lo = b + DATA_W'(1);
        end else begin
            case (op)
                OP_ADD:  result_c.lo = a + b;
                OP_SUB:  result_c.lo = a - b;
                OP_AND:  result_c.lo = a & b;
                OP_OR:   result_c.lo = a | b;
                OP_SHR:  result_c.lo = a >> shamt;
                OP_SHRA: result_c.lo = DATA_W'($signed(a) >>> shamt);
                OP_SHL:  result_c.lo = a << shamt;
                OP_ROR:  result_c.lo = (a >> shamt) | (a << rot_back);
                OP_ROL:  result_c.lo = (a << shamt) | (a >> rot_back);
                OP_MUL:  result_c    = prod;
                OP_DIV: begin
                    // Divide by zero leaves 0/0; divide by -1 is negation, avoiding overflow
                    if (b == '0) begin
                        result_c = '0;
                    end else if (&b) begin
                        result_c.lo = '0 - a;
                    end else begin
                        result_c.lo = DATA_W'($signed(a) / $signed(b));
                        result_c.hi = DATA_W'($signed(a) % $signed(b));
                    end
                end
                OP_NEG:  result_c.lo = '0 - b;
                OP_NOT:  result_c.lo = ~b;
                default: result_c    = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU data path: GPR file, special registers, bus mux, RAM and ALU.
module data_path
    import data_path_pkg::*;
(
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic              strobe,
    input  logic              BAOut,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic [DATA_W-1:0] input_data,
    input  logic              IRin,
    input  logic [OP_W-1:0]   op,
    input  logic              HIOut,
    input  logic              LOout,
    input  logic              Zhighout,
    input  logic              Zlowout,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              InPortout,
    input  logic              Yout,
    input  logic              RAMout,
    input  logic              Cout,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              ZHighin,
    input  logic              Zlowin,
    input  logic              PCin,
    input  logic              MDRin,
    input  logic              OutPortin,
    input  logic              Yin,
    input  logic              MARin,
    input  logic              IncPC,
    output logic [DATA_W-1:0] BusOut,
    output logic [DATA_W-1:0] mdrData,
    output logic [DATA_W-1:0] ZHighWire,
    output logic [DATA_W-1:0] ZLowWire,
    output logic [DATA_W-1:0] BusMuxInR0,
    output logic [DATA_W-1:0] BusMuxInR1,
    output logic [DATA_W-1:0] BusMuxInR2,
    output logic [DATA_W-1:0] BusMuxInR3,
    output logic [DATA_W-1:0] BusMuxInR4,
    output logic [DATA_W-1:0] BusMuxInR5,
    output logic [DATA_W-1:0] BusMuxInR6,
    output logic [DATA_W-1:0] BusMuxInR7,
    output logic [DATA_W-1:0] BusMuxInR8,
    output logic [DATA_W-1:0] BusMuxInR9,
    output logic [DATA_W-1:0] BusMuxInR10,
    output logic [DATA_W-1:0] BusMuxInR11,
    output logic [DATA_W-1:0] BusMuxInR12,
    output logic [DATA_W-1:0] BusMuxInR13,
    output logic [DATA_W-1:0] BusMuxInR14,
    output logic [DATA_W-1:0] BusMuxInR15,
    output logic [DATA_W-1:0] BusMuxInZhigh,
    output logic [DATA_W-1:0] BusMuxInZlow,
    output logic [DATA_W-1:0] BusMuxInPCout,
    output logic [DATA_W-1:0] BusMuxInInPortout,
    output logic [DATA_W-1:0] BusMuxInYout,
    output logic [DATA_W-1:0] BusMuxInHI,
    output logic [DATA_W-1:0] BusMuxInLO,
    output logic [DATA_W-1:0] BusMuxInRamout,
    output logic [DATA_W-1:0] output_data,
    output logic [DATA_W-1:0] irOut,
    output logic              branchCompare,
    output logic              R0out,
    output logic              R1out,
    output logic              R2out,
    output logic              R3out,
    output logic              R4out,
    output logic              R5out,
    output logic              R6out,
    output logic              R7out,
    output logic              R8out,
    output logic              R9out,
    output logic              R10out,
    output logic              R11out,
    output logic              R12out,
    output logic              R13out,
    output logic              R14out,
    output logic              R15out,
    output logic              R0in,
    output logic              R1in,
    output logic              R2in,
    output logic              R3in,
    output logic              R4in,
    output logic              R5in,
    output logic              R6in,
    output logic              R7in,
    output logic              R8in,
    output logic              R9in,
    output logic              R10in,
    output logic              R11in,
    output logic              R12in,
    output logic              R13in,
    output logic              R14in,
    output logic              R15in,
    output logic [REG_IDX_W-1:0] to_decode
);

    logic [NUM_GPR-1:0][DATA_W-1:0] gpr;
    logic [DATA_W-1:0]     pc, ir, mdr, y, zhi, zlo, hi, lo, in_port, out_port;
    logic [RAM_ADDR_W-1:0] mar;
    logic [DATA_W-1:0]     ram [RAM_DEPTH];
    logic [DATA_W-1:0]     ram_rd, c_sext, bus;
    logic [REG_IDX_W-1:0]  ra, rb, rc, sel;
    logic [NUM_GPR-1:0]    gpr_in, gpr_out;
    alu_result_t           alu_res;

    assign ra     = ir[RA_LSB +: REG_IDX_W];
    assign rb     = ir[RB_LSB +: REG_IDX_W];
    assign rc     = ir[RC_LSB +: REG_IDX_W];
    assign c_sext = sign_ext_imm(ir[IMM_W-1:0]);
    assign ram_rd = ram[mar];

    // Register select; no field select falls through to R15 (jal link)
    always_comb begin
        sel = REG_IDX_W'(NUM_GPR - 1);
        if (Gra)      sel = ra;
        else if (Grb) sel = rb;
        else if (Grc) sel = rc;
    end

    assign gpr_in  = Rin ? (NUM_GPR'(1) << sel) : '0;
    assign gpr_out = (Rout | BAOut) ? (NUM_GPR'(1) << sel) : '0;

    // Bus mux, first-listed source wins; BAOut reads R0 as zero
    always_comb begin
        bus = '0;
        if (|gpr_out)       bus = (BAOut && sel == '0) ? '0 : gpr[sel];
        else if (HIOut)     bus = hi;
        else if (LOout)     bus = lo;
        else if (Zhighout)  bus = zhi;
        else if (Zlowout)   bus = zlo;
        else if (PCout)     bus = pc;
        else if (MDRout)    bus = mdr;
        else if (InPortout) bus = in_port;
        else if (Yout)      bus = y;
        else if (RAMout)    bus = ram_rd;
        else if (Cout)      bus = c_sext;
    end

    data_path_alu u_alu (
        .a        (y),
        .b        (bus),
        .op       (op),
        .inc_pc   (IncPC),
        .result_c (alu_res)
    );

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            gpr      <= '0;
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            zhi      <= '0;
            zlo      <= '0;
            hi       <= '0;
            lo       <= '0;
            in_port  <= '0;
            out_port <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_GPR; k++) begin
                if (gpr_in[k]) gpr[k] <= bus;
            end
            if (PCin)      pc       <= bus;
            if (IRin)      ir       <= bus;
            if (MARin)     mar      <= bus[RAM_ADDR_W-1:0];
            if (MDRin)     mdr      <= Read ? ram_rd : bus;
            if (Yin)       y        <= bus;
            if (ZHighin)   zhi      <= alu_res.hi;
            if (Zlowin)    zlo      <= alu_res.lo;
            if (HIin)      hi       <= bus;
            if (LOin)      lo       <= bus;
            if (strobe)    in_port  <= input_data;
            if (OutPortin) out_port <= bus;
        end
    end

    // RAM is not reset; writes take the pre-edge MDR and are blocked during clear
    always_ff @(posedge Clock) begin
        if (Write && !clear) ram[mar] <= mdr;
    end

    always_comb begin
        branchCompare = 1'b0;
        case (ir[C2_LSB +: C2_W])
            2'b00:   branchCompare = (bus == '0);
            2'b01:   branchCompare = (bus != '0);
            2'b10:   branchCompare = !bus[DATA_W-1] && (bus != '0);
            default: branchCompare = bus[DATA_W-1];
        endcase
    end

    assign BusOut            = bus;
    assign mdrData           = mdr;
    assign ZHighWire         = zhi;
    assign ZLowWire          = zlo;
    assign BusMuxInZhigh     = zhi;
    assign BusMuxInZlow      = zlo;
    assign BusMuxInPCout     = pc;
    assign BusMuxInInPortout = in_port;
    assign BusMuxInYout      = y;
    assign BusMuxInHI        = hi;
    assign BusMuxInLO        = lo;
    assign BusMuxInRamout    = ram_rd;
    assign output_data       = out_port;
    assign irOut             = ir;
    assign to_decode         = sel;

    assign BusMuxInR0  = gpr[0];
    assign BusMuxInR1  = gpr[1];
    assign BusMuxInR2  = gpr[2];
    assign BusMuxInR3  = gpr[3];
    assign BusMuxInR4  = gpr[4];
    assign BusMuxInR5  = gpr[5];
    assign BusMuxInR6  = gpr[6];
    assign BusMuxInR7  = gpr[7];
    assign BusMuxInR8  = gpr[8];
    assign BusMuxInR9  = gpr[9];
    assign BusMuxInR10 = gpr[10];
    assign BusMuxInR11 = gpr[11];
    assign BusMuxInR12 = gpr[12];
    assign BusMuxInR13 = gpr[13];
    assign BusMuxInR14 = gpr[14];
    assign BusMuxInR15 = gpr[15];

    assign R0out  = gpr_out[0];
    assign R1out  = gpr_out[1];
    assign R2out  = gpr_out[2];
    assign R3out  = gpr_out[3];
    assign R4out  = gpr_out[4];
    assign R5out  = gpr_out[5];
    assign R6out  = gpr_out[6];
    assign R7out  = gpr_out[7];
    assign R8out  = gpr_out[8];
    assign R9out  = gpr_out[9];
    assign R10out = gpr_out[10];
    assign R11out = gpr_out[11];
    assign R12out = gpr_out[12];
    assign R13out = gpr_out[13];
    assign R14out = gpr_out[14];
    assign R15out = gpr_out[15];

    assign R0in  = gpr_in[0];
    assign R1in  = gpr_in[1];
    assign R2in  = gpr_in[2];
    assign R3in  = gpr_in[3];
    assign R4in  = gpr_in[4];
    assign R5in  = gpr_in[5];
    assign R6in  = gpr_in[6];
    assign R7in  = gpr_in[7];
    assign R8in  = gpr_in[8];
    assign R9in  = gpr_in[9];
    assign R10in = gpr_in[10];
    assign R11in = gpr_in[11];
    assign R12in = gpr_in[12];
    assign R13in = gpr_in[13];
    assign R14in = gpr_in[14];
    assign R15in = gpr_in[15];

endmodule

// File: tb/tb_data_path.sv
// Randomized bench for data_path against a register-level behavioural model.
module tb_data_path;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic        Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout, IRin;
    logic [31:0] input_data;
    logic [4:0]  op;
    logic        HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout;
    logic        HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC;

    wire [31:0]       BusOut, mdrData, ZHighWire, ZLowWire;
    wire [15:0][31:0] gpr_w;
    wire [31:0]       bm_zh, bm_zl, bm_pc, bm_inp, bm_y, bm_hi, bm_lo, bm_ram, output_data, irOut;
    wire              branchCompare;
    wire [15:0]       rout_w, rin_w;
    wire [3:0]        to_decode;

    data_path dut (
        .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .strobe(strobe),
        .BAOut(BAOut), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .input_data(input_data), .IRin(IRin), .op(op),
        .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
        .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout), .RAMout(RAMout), .Cout(Cout),
        .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin), .PCin(PCin),
        .MDRin(MDRin), .OutPortin(OutPortin), .Yin(Yin), .MARin(MARin), .IncPC(IncPC),
        .BusOut(BusOut), .mdrData(mdrData), .ZHighWire(ZHighWire), .ZLowWire(ZLowWire),
        .BusMuxInR0(gpr_w[0]), .BusMuxInR1(gpr_w[1]), .BusMuxInR2(gpr_w[2]), .BusMuxInR3(gpr_w[3]),
        .BusMuxInR4(gpr_w[4]), .BusMuxInR5(gpr_w[5]), .BusMuxInR6(gpr_w[6]), .BusMuxInR7(gpr_w[7]),
        .BusMuxInR8(gpr_w[8]), .BusMuxInR9(gpr_w[9]), .BusMuxInR10(gpr_w[10]), .BusMuxInR11(gpr_w[11]),
        .BusMuxInR12(gpr_w[12]), .BusMuxInR13(gpr_w[13]), .BusMuxInR14(gpr_w[14]), .BusMuxInR15(gpr_w[15]),
        .BusMuxInZhigh(bm_zh), .BusMuxInZlow(bm_zl), .BusMuxInPCout(bm_pc),
        .BusMuxInInPortout(bm_inp), .BusMuxInYout(bm_y), .BusMuxInHI(bm_hi), .BusMuxInLO(bm_lo),
        .BusMuxInRamout(bm_ram), .output_data(output_data), .irOut(irOut),
        .branchCompare(branchCompare),
        .R0out(rout_w[0]), .R1out(rout_w[1]), .R2out(rout_w[2]), .R3out(rout_w[3]),
        .R4out(rout_w[4]), .R5out(rout_w[5]), .R6out(rout_w[6]), .R7out(rout_w[7]),
        .R8out(rout_w[8]), .R9out(rout_w[9]), .R10out(rout_w[10]), .R11out(rout_w[11]),
        .R12out(rout_w[12]), .R13out(rout_w[13]), .R14out(rout_w[14]), .R15out(rout_w[15]),
        .R0in(rin_w[0]), .R1in(rin_w[1]), .R2in(rin_w[2]), .R3in(rin_w[3]),
        .R4in(rin_w[4]), .R5in(rin_w[5]), .R6in(rin_w[6]), .R7in(rin_w[7]),
        .R8in(rin_w[8]), .R9in(rin_w[9]), .R10in(rin_w[10]), .R11in(rin_w[11]),
        .R12in(rin_w[12]), .R13in(rin_w[13]), .R14in(rin_w[14]), .R15in(rin_w[15]),
        .to_decode(to_decode)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zh, m_zl, m_hi, m_lo, m_inp, m_outp;
    logic [31:0] m_ram [512];
    bit          m_ok  [512];

    logic [4:0] ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                             5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 16; k++) m_r[k] = '0;
        m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_zh = '0; m_zl = '0;
        m_hi = '0; m_lo = '0; m_inp = '0; m_outp = '0;
    endtask

    function automatic int unsigned sel_idx();
        if (Gra) return int'(m_ir[26:23]);
        if (Grb) return int'(m_ir[22:19]);
        if (Grc) return int'(m_ir[18:15]);
        return 15;
    endfunction

    function automatic logic [31:0] exp_bus();
        int unsigned k;
        k = sel_idx();
        if (Rout || BAOut) return (BAOut && k == 0) ? 32'd0 : m_r[k];
        if (HIOut)     return m_hi;
        if (LOout)     return m_lo;
        if (Zhighout)  return m_zh;
        if (Zlowout)   return m_zl;
        if (PCout)     return m_pc;
        if (MDRout)    return m_mdr;
        if (InPortout) return m_inp;
        if (Yout)      return m_y;
        if (RAMout)    return m_ram[m_mar[8:0]];
        if (Cout)      return {{13{m_ir[18]}}, m_ir[18:0]};
        return 32'd0;
    endfunction

    // Reference ALU from the opcode table using integer arithmetic
    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] f, input logic inc);
        int unsigned s;
        longint      p;
        int          q, r;
        s = int'(b[4:0]);
        if (inc) return {32'd0, b + 32'd1};
        case (f)
            5'b00011: return {32'd0, a + b};
            5'b00100: return {32'd0, a - b};
            5'b00101: return {32'd0, a & b};
            5'b00110: return {32'd0, a | b};
            5'b00111: return {32'd0, a >> s};
            5'b01000: begin q = int'(a) >>> s; return {32'd0, 32'(q)}; end
            5'b01001: return {32'd0, a << s};
            5'b01010: return (s == 0) ? {32'd0, a} : {32'd0, (a >> s) | (a << (32 - s))};
            5'b01011: return (s == 0) ? {32'd0, a} : {32'd0, (a << s) | (a >> (32 - s))};
            5'b01111: begin p = longint'(int'(a)) * longint'(int'(b)); return 64'(p); end
            5'b10000: begin
                if (b == 32'd0) return 64'd0;
                if (int'(b) == -1) return {32'd0, 32'd0 - a};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {32'(r), 32'(q)};
            end
            5'b10001: return {32'd0, 32'd0 - b};
            5'b10010: return {32'd0, ~b};
            default:  return 64'd0;
        endcase
    endfunction

    function automatic logic exp_branch(input logic [31:0] b);
        case (m_ir[20:19])
            2'b00:   return b == 0;
            2'b01:   return b != 0;
            2'b10:   return int'(b) > 0;
            default: return int'(b) < 0;
        endcase
    endfunction

    // Model advances on each rising edge unless held in clear
    always @(posedge Clock) begin
        logic [31:0] b, rd;
        logic [63:0] z;
        int unsigned k, a;
        if (!clear) begin
            b  = exp_bus();
            z  = ref_alu(m_y, b, op, IncPC);
            k  = sel_idx();
            a  = int'(m_mar[8:0]);
            rd = m_ram[a];
            if (Write) begin m_ram[a] = m_mdr; m_ok[a] = 1'b1; end
            if (MDRin) m_mdr = Read ? rd : b;
            if (Rin) m_r[k] = b;
            if (PCin) m_pc = b;
            if (IRin) m_ir = b;
            if (MARin) m_mar = b;
            if (Yin) m_y = b;
            if (ZHighin) m_zh = z[63:32];
            if (Zlowin) m_zl = z[31:0];
            if (HIin) m_hi = b;
            if (LOin) m_lo = b;
            if (strobe) m_inp = input_data;
            if (OutPortin) m_outp = b;
        end
    end

    // Compare every visible output against the model mid-cycle
    always @(negedge Clock) begin
        logic [31:0] b;
        int unsigned k;
        b = exp_bus();
        k = sel_idx();
        chk("BusOut", BusOut, b);
        chk("mdrData", mdrData, m_mdr);
        chk("ZHighWire", ZHighWire, m_zh);
        chk("ZLowWire", ZLowWire, m_zl);
        chk("BusMuxInZhigh", bm_zh, m_zh);
        chk("BusMuxInZlow", bm_zl, m_zl);
        chk("PC", bm_pc, m_pc);
        chk("InPort", bm_inp, m_inp);
        chk("Y", bm_y, m_y);
        chk("HI", bm_hi, m_hi);
        chk("LO", bm_lo, m_lo);
        chk("output_data", output_data, m_outp);
        chk("irOut", irOut, m_ir);
        for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), gpr_w[i], m_r[i]);
        if (m_ok[m_mar[8:0]]) chk("Ramout", bm_ram, m_ram[m_mar[8:0]]);
        chk("branchCompare", branchCompare, exp_branch(b));
        chk("to_decode", to_decode, k);
        chk("Rin_decode", rin_w, Rin ? (64'd1 << k) : 64'd0);
        chk("Rout_decode", rout_w, (Rout || BAOut) ? (64'd1 << k) : 64'd0);
    end

    task automatic idle();
        {Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout, IRin} = '0;
        {HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout} = '0;
        {HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC} = '0;
        op = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic load_inport(input logic [31:0] v);
        idle(); strobe = 1'b1; input_data = v; tick();
    endtask

    task automatic write_ram(input logic [8:0] addr, input logic [31:0] data);
        load_inport({23'd0, addr});
        idle(); InPortout = 1'b1; MARin = 1'b1; strobe = 1'b1; input_data = data; tick();
        idle(); InPortout = 1'b1; MDRin = 1'b1; tick();
        idle(); Write = 1'b1; tick();
    endtask

    task automatic rand_cycle();
        int src;
        idle();
        src = $urandom_range(0, 13);
        case (src)
            1: Rout = 1'b1;       2: BAOut = 1'b1;     3: HIOut = 1'b1;    4: LOout = 1'b1;
            5: Zhighout = 1'b1;   6: Zlowout = 1'b1;   7: PCout = 1'b1;    8: MDRout = 1'b1;
            9: InPortout = 1'b1;  10: Yout = 1'b1;     11: RAMout = 1'b1;  12: Cout = 1'b1;
            default: ;
        endcase
        {Gra, Grb, Grc} = 3'($urandom);
        Rin = ($urandom_range(0, 3) == 0);   IRin = ($urandom_range(0, 5) == 0);
        HIin = ($urandom_range(0, 3) == 0);  LOin = ($urandom_range(0, 3) == 0);
        ZHighin = ($urandom_range(0, 1) == 0); Zlowin = ($urandom_range(0, 1) == 0);
        PCin = ($urandom_range(0, 3) == 0);  MDRin = ($urandom_range(0, 3) == 0);
        OutPortin = ($urandom_range(0, 3) == 0); Yin = ($urandom_range(0, 2) == 0);
        MARin = ($urandom_range(0, 3) == 0); IncPC = ($urandom_range(0, 7) == 0);
        Read = ($urandom_range(0, 1) == 0);  Write = ($urandom_range(0, 3) == 0);
        strobe = ($urandom_range(0, 1) == 0);
        input_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 12)] : 5'($urandom);
        tick();
    endtask

    initial begin
        idle();
        input_data = '0;
        model_clear();
        for (int i = 0; i < 512; i++) m_ok[i] = 1'b0;
        clear = 1'b1;
        tick(); tick();
        chk("reset_PC", bm_pc, 32'd0);
        chk("reset_IR", irOut, 32'd0);
        clear = 1'b0;
        tick();

        // Fill RAM through the data path; RAM[0] holds addi R4,R3,5
        write_ram(9'd0, 32'h0A18_0005);
        for (int i = 1; i < 512; i++) write_ram(9'(i), $urandom);

        // Fetch
        idle(); PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; tick();
        chk("fetch_zlo", ZLowWire, 32'd1);
        chk("fetch_zhi", ZHighWire, 32'd0);
        idle(); Zlowout = 1'b1; PCin = 1'b1; tick();
        chk("fetch_pc", bm_pc, 32'd1);
        idle(); Read = 1'b1; MDRin = 1'b1; tick();
        chk("fetch_mdr", mdrData, 32'h0A18_0005);
        idle(); MDRout = 1'b1; IRin = 1'b1; tick();
        chk("fetch_ir", irOut, 32'h0A18_0005);

        // addi R4,R3,5 with R3=7
        load_inport(32'd7);
        idle(); InPortout = 1'b1; Grb = 1'b1; Rin = 1'b1; tick();
        chk("R3_load", gpr_w[3], 32'd7);
        idle(); Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; #1;
        chk("addi_bus_rb", BusOut, 32'd7);
        tick();
        chk("addi_y", bm_y, 32'd7);
        idle(); Cout = 1'b1; op = 5'b00011; ZHighin = 1'b1; Zlowin = 1'b1; #1;
        chk("addi_bus_c", BusOut, 32'd5);
        tick();
        chk("addi_z", ZLowWire, 32'd12);
        idle(); Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; #1;
        chk("addi_R4in", rin_w, 16'h0010);
        tick();
        chk("addi_R4", gpr_w[4], 32'd12);

        // IR with ra=6, rb=0
        load_inport(32'h0300_0000);
        idle(); InPortout = 1'b1; IRin = 1'b1; tick();
        load_inport(32'h40);
        idle(); InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
        load_inport(32'hFFFF);
        idle(); InPortout = 1'b1; Grb = 1'b1; Rin = 1'b1; tick();
        chk("R0_load", gpr_w[0], 32'hFFFF);
        idle(); Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; #1;
        chk("baout_r0_bus", BusOut, 32'd0);
        tick();
        chk("baout_r0_y", bm_y, 32'd0);
        idle(); Grb = 1'b1; Rout = 1'b1; #1;
        chk("rout_r0_bus", BusOut, 32'hFFFF);
        chk("branch_r0_nonzero", branchCompare, 1'b0);
        tick();

        // jr / jal
        idle(); Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; tick();
        chk("jr_pc", bm_pc, 32'h40);
        load_inport(32'd2);
        idle(); InPortout = 1'b1; Rin = 1'b1; tick();
        chk("jal_R15", gpr_w[15], 32'd2);

        // mul -3 * 4, div 7 / 2
        load_inport(32'hFFFF_FFFD);
        idle(); InPortout = 1'b1; Yin = 1'b1; strobe = 1'b1; input_data = 32'd4; tick();
        idle(); InPortout = 1'b1; op = 5'b01111; ZHighin = 1'b1; Zlowin = 1'b1; tick();
        chk("mul", {ZHighWire, ZLowWire}, 64'hFFFF_FFFF_FFFF_FFF4);
        load_inport(32'd7);
        idle(); InPortout = 1'b1; Yin = 1'b1; strobe = 1'b1; input_data = 32'd2; tick();
        idle(); InPortout = 1'b1; op = 5'b10000; ZHighin = 1'b1; Zlowin = 1'b1; tick();
        chk("div_q", ZLowWire, 32'd3);
        chk("div_r", ZHighWire, 32'd1);

        // Random traffic with an asynchronous clear pulse in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                clear = 1'b1;
                model_clear();
                #1;
                for (int i = 0; i < 16; i++) chk($sformatf("clr_R%0d", i), gpr_w[i], 32'd0);
                chk("clr_PC", bm_pc, 32'd0);
                chk("clr_IR", irOut, 32'd0);
                chk("clr_Y", bm_y, 32'd0);
                chk("clr_Z", {bm_zh, bm_zl}, 64'd0);
                chk("clr_HILO", {bm_hi, bm_lo}, 64'd0);
                chk("clr_InPort", bm_inp, 32'd0);
                chk("clr_OutPort", output_data, 32'd0);
                chk("clr_MDR", mdrData, 32'd0);
                rand_cycle();
                rand_cycle();
                clear = 1'b0;
            end
            rand_cycle();
        end

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
